// File: rtl/vdp_pkg.sv
// Shared video-pipeline types and line geometry.
// Used by the line buffer, the palette stage and the timing generator.
package vdp_pkg;
  typedef logic [7:0] colour_t;

  localparam int H_ACTIVE    = 640;
  localparam int PALETTE_LAT = 1;
endpackage

// File: rtl/line_bank_bram.sv
// Simple dual-port line RAM holding both ping-pong banks, addressed {bank, addr}.
// Reads are registered: data appears the cycle after the address.
module line_bank_bram
  import vdp_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic            clk_pix,
  input  logic            i_wr_en,
  input  logic [ADDR_W:0] i_wr_addr,
  input  colour_t         i_wr_data,
  input  logic [ADDR_W:0] i_rd_addr,
  output colour_t         o_rd_data
);
  colour_t r_mem [2**(ADDR_W+1)];
  colour_t r_rd_data;

  // Write port and registered read port; contents are never cleared.
  always_ff @(posedge clk_pix) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/line_scanout.sv
// Ping-pong line buffer: fill engine writes the back bank while the front bank scans out
// with horizontal scroll; timing strobes are delayed to line up after the palette lookup.
module line_scanout
  import vdp_pkg::*;
#(
  parameter int H_ACTIVE = vdp_pkg::H_ACTIVE,
  parameter int ADDR_W   = 10,
  parameter int PAL_LAT  = vdp_pkg::PALETTE_LAT
) (
  input  logic              clk_pix,
  input  logic              rst_pix,
  input  logic              de_i,
  input  logic              hsync_i,
  input  logic              vsync_i,
  input  logic [ADDR_W-1:0] scroll_x,
  input  logic              fill_valid,
  output logic              fill_ready,
  input  colour_t           fill_data,
  input  logic              fill_last,
  output logic              fill_req,
  input  logic              underrun_clr,
  output logic              underrun,
  output colour_t           colour_pix,
  output logic              de_o,
  output logic              hsync_o,
  output logic              vsync_o
);
  localparam int                DLY    = 2 + PAL_LAT;
  localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(H_ACTIVE - 1);
  localparam logic [ADDR_W:0]   H_EXT  = (ADDR_W+1)'(H_ACTIVE);

  logic              r_front, r_rst_q, r_de_prev;
  logic              r_fill_ready, r_fill_req, r_underrun;
  logic [ADDR_W-1:0] r_wr_ptr, r_x, r_scroll;
  logic [DLY-1:0]    r_de_sr, r_hs_sr, r_vs_sr;
  colour_t           r_colour;

  logic              w_accept, w_complete, w_rise, w_fall, w_swap, w_underrun;
  logic [ADDR_W-1:0] w_x, w_scroll, w_rd_addr;
  logic [ADDR_W:0]   w_sum;
  colour_t           w_rd_data;

  // Handshake, line-edge detection and scrolled read address.
  always_comb begin
    w_accept   = fill_valid && r_fill_ready;
    // back bank is complete if already full or this beat finishes it
    w_complete = !r_fill_ready || (w_accept && (fill_last || (r_wr_ptr == X_LAST)));
    w_rise     = de_i && !r_de_prev;
    w_fall     = !de_i && r_de_prev;
    w_swap     = w_fall && w_complete;
    w_underrun = w_fall && !w_complete;
    if (w_rise) begin
      w_x      = '0;
      w_scroll = ADDR_W'({1'b0, scroll_x} % H_EXT);
    end else begin
      w_x      = r_x;
      w_scroll = r_scroll;
    end
    w_sum = {1'b0, w_x} + {1'b0, w_scroll};
    if (w_sum >= H_EXT) begin
      w_rd_addr = ADDR_W'(w_sum - H_EXT);
    end else begin
      w_rd_addr = w_sum[ADDR_W-1:0];
    end
  end

  // Bank ownership, fill pointer, scan counter and status flags.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      r_rst_q      <= 1'b1;
      r_de_prev    <= 1'b0;
      r_fill_req   <= 1'b0;
      r_front      <= 1'b0;
      r_fill_ready <= 1'b1;
      r_wr_ptr     <= '0;
      r_x          <= '0;
      r_scroll     <= '0;
      r_underrun   <= 1'b0;
    end else begin
      r_rst_q    <= 1'b0;
      r_de_prev  <= de_i;
      r_fill_req <= r_rst_q || w_swap;
      r_scroll   <= w_scroll;
      if (de_i) begin
        r_x <= (w_x == X_LAST) ? '0 : w_x + ADDR_W'(1);
      end
      if (w_swap) begin
        r_front      <= ~r_front;
        r_fill_ready <= 1'b1;
        r_wr_ptr     <= '0;
      end else begin
        if (w_accept) begin
          r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
        end
        if (w_complete) begin
          r_fill_ready <= 1'b0;
        end
      end
      if (w_underrun) begin
        r_underrun <= 1'b1;
      end else if (underrun_clr) begin
        r_underrun <= 1'b0;
      end
    end
  end

  // Strobe delay lines and the blanked colour output register.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      r_de_sr  <= '0;
      r_hs_sr  <= '0;
      r_vs_sr  <= '0;
      r_colour <= '0;
    end else begin
      r_de_sr  <= {r_de_sr[DLY-2:0], de_i};
      r_hs_sr  <= {r_hs_sr[DLY-2:0], hsync_i};
      r_vs_sr  <= {r_vs_sr[DLY-2:0], vsync_i};
      r_colour <= r_de_sr[0] ? w_rd_data : '0;
    end
  end

  line_bank_bram #(.ADDR_W(ADDR_W)) u_bram (
    .clk_pix   (clk_pix),
    .i_wr_en   (w_accept),
    .i_wr_addr ({~r_front, r_wr_ptr}),
    .i_wr_data (fill_data),
    .i_rd_addr ({r_front, w_rd_addr}),
    .o_rd_data (w_rd_data)
  );

  assign fill_ready = r_fill_ready;
  assign fill_req   = r_fill_req;
  assign underrun   = r_underrun;
  assign colour_pix = r_colour;
  assign de_o       = r_de_sr[DLY-1];
  assign hsync_o    = r_hs_sr[DLY-1];
  assign vsync_o    = r_vs_sr[DLY-1];
endmodule

// File: tb/tb_line_scanout.sv
// Bench for line_scanout: line-level reference model compared every cycle,
// plus directed lines with hand-computed pixel expectations.
module tb_line_scanout;
  import vdp_pkg::*;
  localparam int H = 640;

  logic       clk_pix = 1'b0, rst_pix = 1'b1;
  logic       de_i = 1'b0, hsync_i = 1'b0, vsync_i = 1'b0;
  logic [9:0] scroll_x = 10'd0;
  logic       fill_valid = 1'b0, fill_last = 1'b0, underrun_clr = 1'b0;
  logic [7:0] fill_data = 8'd0;
  logic       fill_ready, fill_req, underrun, de_o, hsync_o, vsync_o;
  logic [7:0] colour_pix;

  line_scanout dut (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .de_i(de_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
    .scroll_x(scroll_x), .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_data(fill_data),
    .fill_last(fill_last), .fill_req(fill_req), .underrun_clr(underrun_clr), .underrun(underrun),
    .colour_pix(colour_pix), .de_o(de_o), .hsync_o(hsync_o), .vsync_o(vsync_o)
  );

  always #5 clk_pix = ~clk_pix;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (line/bank level) ----------------
  logic [7:0] m_mem   [2][H];
  bit         m_known [2][H];
  int  m_front = 0, m_wr = 0, m_x = 0, m_scroll = 0;
  bit  m_full = 0, m_und = 0, m_de_prev = 0, m_valid = 0;
  // history, index 0 = most recently sampled cycle
  bit         h_rst [4] = '{1, 1, 1, 1};
  bit         h_de [4], h_hs [4], h_vs [4], h_pv [4], h_pk [4];
  logic [7:0] h_pval [4];
  bit         e_ready, e_und, e_req, e_de, e_hs, e_vs, e_ck;
  logic [7:0] e_col;

  always @(posedge clk_pix) begin
    bit pv, pk, swp, ok, clean3;
    logic [7:0] pval;
    int a;
    pv = 0; pk = 0; swp = 0; pval = 8'd0;
    if (rst_pix) begin
      m_front = 0; m_wr = 0; m_full = 0; m_und = 0; m_de_prev = 0;
    end else begin
      if (de_i) begin
        if (!m_de_prev) begin
          m_x = 0;
          m_scroll = int'(scroll_x) % H;
        end
        a = (m_x + m_scroll) % H;
        pv = 1; pk = m_known[m_front][a]; pval = m_mem[m_front][a];
        m_x++;
      end
      if (fill_valid && !m_full) begin
        m_mem[1-m_front][m_wr] = fill_data;
        m_known[1-m_front][m_wr] = 1;
        if (fill_last || m_wr == H-1) m_full = 1;
        m_wr++;
      end
      if (!de_i && m_de_prev) begin
        if (m_full) begin
          m_front = 1 - m_front; m_full = 0; m_wr = 0; swp = 1;
        end else begin
          m_und = 1;
        end
      end else if (underrun_clr) begin
        m_und = 0;
      end
      m_de_prev = de_i;
    end
    for (int i = 3; i > 0; i--) begin
      h_rst[i] = h_rst[i-1]; h_de[i] = h_de[i-1]; h_hs[i] = h_hs[i-1]; h_vs[i] = h_vs[i-1];
      h_pv[i] = h_pv[i-1]; h_pk[i] = h_pk[i-1]; h_pval[i] = h_pval[i-1];
    end
    h_rst[0] = rst_pix; h_de[0] = de_i; h_hs[0] = hsync_i; h_vs[0] = vsync_i;
    h_pv[0] = pv; h_pk[0] = pk; h_pval[0] = pval;
    e_ready = !m_full;
    e_und   = m_und;
    e_req   = !h_rst[0] && (h_rst[1] || swp);
    clean3  = !h_rst[0] && !h_rst[1] && !h_rst[2];
    e_de    = clean3 && h_de[2];
    e_hs    = clean3 && h_hs[2];
    e_vs    = clean3 && h_vs[2];
    ok      = !h_rst[0] && !h_rst[1] && h_pv[1];
    e_col   = ok ? h_pval[1] : 8'd0;
    e_ck    = !ok || h_pk[1];
    m_valid = 1;
  end

  always @(negedge clk_pix) begin
    if (m_valid) begin
      chk("fill_ready", fill_ready, e_ready);
      chk("underrun", underrun, e_und);
      chk("fill_req", fill_req, e_req);
      chk("de_o", de_o, e_de);
      chk("hsync_o", hsync_o, e_hs);
      chk("vsync_o", vsync_o, e_vs);
      if (e_ck) chk("colour_pix", colour_pix, e_col);
    end
  end

  // ---------------- stimulus ----------------
  int f_idx = 0, f_target = 0, f_pat = 0, f_last_at = -1, rdy_chk_j = -1;
  bit f_rand = 0, d_ready = 0, rnd_clr = 0;
  int lit_px[$], lit_val[$];

  function automatic logic [7:0] pat(input int p, input int b);
    case (p)
      0:       return 8'(b);
      1:       return 8'(b * 3);
      2:       return 8'(b + 7);
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic cycle(input bit de, input bit hs, input bit vs, input bit rst);
    @(negedge clk_pix);
    if (fill_valid && d_ready) f_idx++;
    rst_pix = rst; de_i = de; hsync_i = hs; vsync_i = vs;
    if (rnd_clr) underrun_clr = ($urandom_range(0, 63) == 0);
    if (!rst && f_idx < f_target) begin
      fill_valid = f_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      fill_data  = pat(f_pat, f_idx);
      fill_last  = (f_idx == f_last_at);
    end else begin
      fill_valid = 1'b0;
      fill_last  = 1'b0;
    end
    d_ready = fill_ready;
  endtask

  // One active line then blanking; colour of pixel j-2 is visible after driving cycle j.
  task automatic line(input int scr, input int nblank, input bit vs, input bit align);
    scroll_x = 10'(scr);
    for (int j = 0; j < H + nblank; j++) begin
      cycle(j < H, (j >= H + 1) && (j < H + 4), vs, 1'b0);
      if (align && j == 2) chk("de_o_lead", de_o, 0);
      if (align && j == 3) chk("de_o_rise", de_o, 1);
      if (j == rdy_chk_j - 1) chk("fill_ready_hold", fill_ready, 1);
      if (j == rdy_chk_j) chk("fill_ready_drop", fill_ready, 0);
      foreach (lit_px[k]) if (lit_px[k] == j - 2) chk("lit_colour", colour_pix, lit_val[k]);
    end
    lit_px.delete();
    lit_val.delete();
  endtask

  initial begin
    repeat (3) cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    chk("rst_fill_ready", fill_ready, 1);
    chk("rst_underrun", underrun, 0);
    chk("rst_colour", colour_pix, 0);
    chk("rst_fill_req", fill_req, 0);
    cycle(0, 0, 0, 0); chk("req_pulse", fill_req, 1);
    cycle(0, 0, 0, 0); chk("req_end", fill_req, 0);
    repeat (4) cycle(0, 0, 0, 0);

    // line 1: fill i&255 with last, front bank still unwritten
    f_idx = 0; f_target = H; f_pat = 0; f_last_at = H - 1;
    line(0, 8, 0, 1);
    // line 2: shows i&255; refill same pattern
    f_idx = 0; f_target = H; f_last_at = -1;
    lit_px = '{0, 1, 255, 256, 300}; lit_val = '{0, 1, 255, 0, 44};
    line(0, 8, 0, 1);
    // line 3: scroll 630 wraps seamlessly; only 300 beats of (3i)&255
    f_idx = 0; f_target = 300; f_pat = 1;
    lit_px = '{0, 9, 10, 11, 639}; lit_val = '{118, 127, 0, 1, 117};
    line(630, 8, 1, 1);
    chk("underrun_set", underrun, 1);
    // line 4: old line repeats while the fill finishes
    f_target = H;
    lit_px = '{0, 5, 300}; lit_val = '{0, 5, 44};
    line(0, 8, 0, 1);
    underrun_clr = 1'b1;
    cycle(0, 0, 0, 0);
    underrun_clr = 1'b0;
    chk("underrun_clr", underrun, 0);
    // line 5: shows (3i)&255; early fill_last on the 100th beat
    f_idx = 0; f_target = 100; f_pat = 2; f_last_at = 99; rdy_chk_j = 100;
    lit_px = '{7, 100, 639}; lit_val = '{21, 44, 125};
    line(0, 8, 0, 1);
    rdy_chk_j = -1;
    // line 6: new entries 0..99, stale i&255 beyond
    f_idx = 0; f_target = 0; f_last_at = -1;
    lit_px = '{0, 99, 100, 101}; lit_val = '{7, 106, 100, 101};
    line(0, 8, 0, 1);
    chk("underrun_again", underrun, 1);

    // reset in the middle of a line and a fill
    f_idx = 0; f_target = H; f_pat = 3; f_rand = 1; scroll_x = 10'd0;
    for (int j = 0; j < 200; j++) cycle(1, 0, 0, 0);
    f_target = 0;
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);
    chk("mid_rst_colour", colour_pix, 0);
    chk("mid_rst_de_o", de_o, 0);
    chk("mid_rst_fill_ready", fill_ready, 1);
    chk("mid_rst_underrun", underrun, 0);
    chk("mid_rst_fill_req", fill_req, 0);
    f_idx = 0; f_rand = 0;
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0); chk("req_repulse", fill_req, 1);
    cycle(0, 0, 0, 0); chk("req_repulse_end", fill_req, 0);
    repeat (4) cycle(0, 0, 0, 0);

    // randomized lines
    rnd_clr = 1;
    repeat (6) begin
      f_idx = 0;
      f_target = $urandom_range(0, H);
      f_pat = 3;
      f_rand = 1'($urandom_range(0, 1));
      f_last_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, H - 1)) : -1;
      line($urandom_range(0, 1023), $urandom_range(4, 40), 1'($urandom_range(0, 1)), 1);
    end
    rnd_clr = 0;
    underrun_clr = 1'b0;
    repeat (4) cycle(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
